// File: rtl/addsub_slice_seq.sv
// addsub_slice_seq: multicycle signed add/subtract sequencer.
// Two signed WIDTH-bit operands are accepted through a valid/ready handshake.
// Both operands are sign-extended to EW bits, where EW is WIDTH+1 rounded up
// to an even number. The operation then runs through a 2-bit ripple slice in
// NS = EW/2 clock steps, and the result is handed off through valid/ready.
// Subtraction is done by inverting B before the extension and seeding the
// carry with 1.
// Optional build macro: ADDSUB_SAT_EN. When it is defined, an overflowing
// result is clamped to the most positive or most negative value.

// Single full-adder cell.
module addsub_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// 2-bit ripple adder slice built from two full-adder cells.
module addsub_slice2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);
  logic c_mid_s;

  addsub_fa_cell u_fa0 (
    .a  (a[0]),
    .b  (b[0]),
    .ci (ci),
    .s  (s[0]),
    .co (c_mid_s)
  );

  addsub_fa_cell u_fa1 (
    .a  (a[1]),
    .b  (b[1]),
    .ci (c_mid_s),
    .s  (s[1]),
    .co (co)
  );
endmodule

module addsub_slice_seq #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_ovf,
  output logic             busy
);

  // Extended width is even, so the operands split evenly into 2-bit chunks.
  // At least one guard bit lies above the WIDTH-bit result.
  localparam int EW = ((WIDTH + 2) / 2) * 2;
  localparam int NS = EW / 2;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r,     state_nx_s;
  logic [EW-1:0]     op_a_r,      op_a_nx_s;
  logic [EW-1:0]     op_b_r,      op_b_nx_s;
  logic [EW-1:0]     sum_r,       sum_nx_s;
  logic              carry_r,     carry_nx_s;
  logic [SW-1:0]     step_r,      step_nx_s;
  logic              in_ready_r,  in_ready_nx_s;
  logic              res_valid_r, res_valid_nx_s;
  logic              busy_r,      busy_nx_s;
  logic [WIDTH-1:0]  res_sum_r,   res_sum_nx_s;
  logic              res_ovf_r,   res_ovf_nx_s;

  logic [WIDTH-1:0]  b_sel_s;
  logic [1:0]        slice_sum_s;
  logic              slice_co_s;
  logic [SW:0]       bit_pos_s;
  logic [EW-1:0]     step_sum_s;
  logic              step_ovf_s;
  logic [WIDTH-1:0]  step_res_s;

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SUM_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SUM_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // The operand registers shift right by one chunk per step, so the
  // current chunk is always in bits [1:0].
  addsub_slice2 u_slice (
    .a  (op_a_r[1:0]),
    .b  (op_b_r[1:0]),
    .ci (carry_r),
    .s  (slice_sum_s),
    .co (slice_co_s)
  );

  assign in_ready  = in_ready_r;
  assign res_valid = res_valid_r;
  assign busy      = busy_r;
  assign res_sum   = res_sum_r;
  assign res_ovf   = res_ovf_r;

  // Next-state, datapath and registered-output decode for the sequencer.
  always_comb begin
    state_nx_s   = state_r;
    op_a_nx_s    = op_a_r;
    op_b_nx_s    = op_b_r;
    sum_nx_s     = sum_r;
    carry_nx_s   = carry_r;
    step_nx_s    = step_r;
    res_sum_nx_s = res_sum_r;
    res_ovf_nx_s = res_ovf_r;

    b_sel_s    = in_sub ? ~in_b : in_b;
    bit_pos_s  = {step_r, 1'b0};
    step_sum_s = (sum_r & ~({{(EW-2){1'b0}}, 2'b11} << bit_pos_s))
               | ({{(EW-2){1'b0}}, slice_sum_s} << bit_pos_s);
    // After the last step, the guard bit differs from the result MSB
    // exactly when the signed result is out of range.
    step_ovf_s = step_sum_s[WIDTH] ^ step_sum_s[WIDTH-1];

`ifdef ADDSUB_SAT_EN
    if (step_ovf_s) begin
      if (step_sum_s[WIDTH]) begin
        step_res_s = SUM_MIN;
      end else begin
        step_res_s = SUM_MAX;
      end
    end else begin
      step_res_s = step_sum_s[WIDTH-1:0];
    end
`else
    step_res_s = step_sum_s[WIDTH-1:0];
`endif

    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          op_a_nx_s  = {{(EW-WIDTH){in_a[WIDTH-1]}}, in_a};
          op_b_nx_s  = {{(EW-WIDTH){b_sel_s[WIDTH-1]}}, b_sel_s};
          sum_nx_s   = {EW{1'b0}};
          carry_nx_s = in_sub;
          step_nx_s  = {SW{1'b0}};
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        op_a_nx_s  = {2'b00, op_a_r[EW-1:2]};
        op_b_nx_s  = {2'b00, op_b_r[EW-1:2]};
        sum_nx_s   = step_sum_s;
        carry_nx_s = slice_co_s;
        step_nx_s  = step_r + SW'(1);
        if (step_r == LAST_STEP) begin
          res_sum_nx_s = step_res_s;
          res_ovf_nx_s = step_ovf_s;
          state_nx_s   = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    in_ready_nx_s  = (state_nx_s == IDLE);
    res_valid_nx_s = (state_nx_s == DONE);
    busy_nx_s      = (state_nx_s != IDLE);
  end

  // State, datapath and output registers; async reset drops any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_a_r      <= {EW{1'b0}};
      op_b_r      <= {EW{1'b0}};
      sum_r       <= {EW{1'b0}};
      carry_r     <= 1'b0;
      step_r      <= {SW{1'b0}};
      in_ready_r  <= 1'b1;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      res_sum_r   <= {WIDTH{1'b0}};
      res_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      op_a_r      <= op_a_nx_s;
      op_b_r      <= op_b_nx_s;
      sum_r       <= sum_nx_s;
      carry_r     <= carry_nx_s;
      step_r      <= step_nx_s;
      in_ready_r  <= in_ready_nx_s;
      res_valid_r <= res_valid_nx_s;
      busy_r      <= busy_nx_s;
      res_sum_r   <= res_sum_nx_s;
      res_ovf_r   <= res_ovf_nx_s;
    end
  end

endmodule

// File: tb/tb_addsub_slice_seq.sv
// Self-checking bench for addsub_slice_seq (WIDTH=3).
// Directed cases with literal expectations plus randomized traffic. A
// transaction-level model at negedge predicts handshake and result values.
module tb_addsub_slice_seq;
  localparam int W  = 3;
  localparam int EW = ((W + 2) / 2) * 2;
  localparam int NS = EW / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;
  logic         res_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int n_handoff = 0;

  // Model state: idle / computing (m_wait cycles left) / result held.
  bit           m_idle = 1'b1;
  bit           m_done = 1'b0;
  int           m_wait = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_ovf = 1'b0;

  addsub_slice_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on true signed integers.
  function automatic void model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, output logic [W-1:0] s,
                                   output logic ovf);
    int av, bv, t, lo, hi;
    lo = -(1 << (W - 1));
    hi = (1 << (W - 1)) - 1;
    av = int'(a);
    bv = int'(b);
    if (av > hi) av = av - (1 << W);
    if (bv > hi) bv = bv - (1 << W);
    t = sub ? (av - bv) : (av + bv);
    ovf = (t > hi) || (t < lo);
`ifdef ADDSUB_SAT_EN
    if (t > hi) t = hi;
    else if (t < lo) t = lo;
`endif
    s = W'(t);
  endfunction

  // Compare DUT against the model every negedge, then advance the model
  // to what the next rising edge must do with the inputs now applied.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_idle = 1'b1;
        m_done = 1'b0;
        m_wait = 0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_sum", int'(res_sum), 0);
        chk("rst_res_ovf", int'(res_ovf), 0);
      end else begin
        chk("mdl_in_ready", int'(in_ready), int'(m_idle));
        chk("mdl_res_valid", int'(res_valid), int'(m_done));
        chk("mdl_busy", int'(busy), int'(!m_idle));
        if (m_done) begin
          chk("mdl_res_sum", int'(res_sum), int'(m_sum));
          chk("mdl_res_ovf", int'(res_ovf), int'(m_ovf));
        end
        if (m_idle) begin
          if (in_valid) begin
            model_op(in_a, in_b, in_sub, m_sum, m_ovf);
            m_idle = 1'b0;
            m_wait = NS;
          end
        end else if (!m_done) begin
          m_wait--;
          if (m_wait == 0) m_done = 1'b1;
        end else if (res_ready) begin
          m_done = 1'b0;
          m_idle = 1'b1;
          n_handoff++;
        end
      end
    end
  end

  // Counts edges after an accept until res_valid, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] exp_sum, input logic exp_ovf);
    int lat;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    chk({nm, "_latency"}, lat, NS);
    chk({nm, "_sum"}, int'(res_sum), int'(exp_sum));
    chk({nm, "_ovf"}, int'(res_ovf), int'(exp_ovf));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({nm, "_valid_drop"}, int'(res_valid), 0);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_2_1", 3'b010, 3'b001, 1'b0, 3'b011, 1'b0);
`ifdef ADDSUB_SAT_EN
    run_op("pos_ovf", 3'b011, 3'b001, 1'b0, 3'b011, 1'b1);
    run_op("neg_ovf_sub", 3'b100, 3'b001, 1'b1, 3'b100, 1'b1);
    run_op("sub_min_ovf", 3'b000, 3'b100, 1'b1, 3'b011, 1'b1);
`else
    run_op("pos_ovf", 3'b011, 3'b001, 1'b0, 3'b100, 1'b1);
    run_op("neg_ovf_sub", 3'b100, 3'b001, 1'b1, 3'b011, 1'b1);
    run_op("sub_min_ovf", 3'b000, 3'b100, 1'b1, 3'b100, 1'b1);
`endif
    run_op("sub_neg", 3'b110, 3'b101, 1'b1, 3'b001, 1'b0);
    run_op("sub_min_ok", 3'b111, 3'b100, 1'b1, 3'b011, 1'b0);

    // Backpressure with a new bundle waiting on in_valid.
    in_a = 3'b001; in_b = 3'b001; in_sub = 1'b0; in_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 3'b110; in_b = 3'b101; in_sub = 1'b1;
    wait_result(lat);
    chk("bp_first_latency", lat, NS);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_sum", int'(res_sum), 2);
      chk("bp_hold_ovf", int'(res_ovf), 0);
      chk("bp_hold_in_ready", int'(in_ready), 0);
      chk("bp_hold_valid", int'(res_valid), 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_handoff_valid", int'(res_valid), 0);
    chk("bp_handoff_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_in_ready", int'(in_ready), 0);
    wait_result(lat);
    chk("bp_second_latency", lat, NS);
    chk("bp_second_sum", int'(res_sum), 1);
    chk("bp_second_ovf", int'(res_ovf), 0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset in the middle of RUN.
    in_a = 3'b001; in_b = 3'b010; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_run_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_result", int'(res_valid), 0);
    end

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_sub    = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rand_drained_idle", int'(in_ready), 1);
    chk("rand_handoffs_seen", int'(n_handoff > 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
